krnl_axi_ctrl_regfile: RTL
==========================

KRNL_AXI_CTRL_REGFILE -- requirements
Module: krnl_axi_ctrl_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: AXI4-Lite address width.
REQ-002 SHALL have parameter NUM_ARGS, default 8: number of 32-bit argument registers, legal range 1..64.
REQ-003 SHALL have parameter IRQ_EN, default 1: 1 instantiates GIE/IER/ISR; 0 ties them to 0.
REQ-004 SHALL have port ACLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports AWADDR in ADDR_W, AWVALID in 1, AWREADY out 1: write-address channel.
REQ-007 SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write-data channel.
REQ-008 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1: write-response channel.
REQ-009 SHALL have ports ARADDR in ADDR_W, ARVALID in 1, ARREADY out 1: read-address channel.
REQ-010 SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read-data channel.
REQ-011 SHALL have ports ap_start out 1, ap_continue out 1: ap_ctrl_chain outputs to the kernel.
REQ-012 SHALL have ports ap_done in 1, ap_idle in 1, ap_ready in 1: ap_ctrl_chain status from the kernel.
REQ-013 SHALL have port interrupt  out  1  level interrupt, registered.
REQ-014 SHALL have port args  out  NUM_ARGS*32  argument i on bits [32i+31:32i].

Function
REQ-015 SHALL accept AW and W independently in either order; AWREADY=1 while no address is held and BVALID=0; WREADY=1 while no data is held and BVALID=0.
REQ-016 SHALL commit a write in the cycle both address and data are held, assert BVALID the next cycle, hold it until BREADY, then release both holders.
REQ-017 SHALL set ARREADY=!RVALID; after an AR handshake, RDATA/RRESP SHALL be registered and RVALID asserted the next cycle, held stable until RREADY.
REQ-018 SHALL return RESP=2'b10 (SLVERR) and RDATA=0 for unaligned (addr[1:0]!=0) or unmapped addresses; such writes change no state; mapped accesses return 2'b00.
REQ-019 SHALL map CTRL at 0x000: bit0 ap_start, bit1 ap_done, bit2 ap_idle, bit3 ap_ready, bit4 ap_continue, bit7 auto_restart; other bits read 0.
REQ-020 SHALL set ap_start on a CTRL write with WSTRB[0]&WDATA[0]; SHALL clear it on ap_ready unless auto_restart=1; a set write in the same cycle as ap_ready wins.
REQ-021 SHALL latch ap_done sticky on an ap_done pulse and clear it on a completed CTRL read; a pulse in the same cycle as the read SHALL leave it set.
REQ-022 SHALL reflect ap_idle and ap_ready in CTRL delayed one cycle.
REQ-023 SHALL pulse ap_continue for exactly one cycle after a CTRL write with WDATA[4]=1, or, when auto_restart=1, one cycle after each ap_done.
REQ-024 SHALL map GIE at 0x004 (bit0), IER at 0x008 (bit0 done, bit1 ready), and ISR at 0x00C (bits[1:0], write-1-to-clear).
REQ-025 SHALL set an ISR bit on the matching pulse when its IER bit is 1; set SHALL win over a simultaneous clear.
REQ-026 SHALL drive interrupt = GIE & |ISR, registered.
REQ-027 SHALL map argument i read/write at 0x010+4*i, updated per byte by WSTRB.
REQ-028 SHALL treat addresses at or above 0x010+4*NUM_ARGS as unmapped.

Reset
REQ-029 SHALL on ARESETn=0 asynchronously clear all registers, ap_start, ap_continue, interrupt, BVALID, RVALID, and both write holders.
REQ-030 SHALL hold AWREADY, WREADY, and ARREADY at 0 during reset and assert them one cycle after deassertion.
REQ-031 SHALL abandon any in-flight transaction when reset asserts mid-operation, with no response issued.

Structure
REQ-032 SHALL take the CTRL/GIE/IER/ISR offsets, ARG_BASE=0x010, CTRL bit positions, and RESP codes from shared package krnl_ctrl_pkg.
REQ-033 SHALL be a single module with no sub-modules; the argument bank SHALL be a generate loop.

Verification
REQ-034 SHALL cover: W before AW by 3 cycles to 0x014, data 0xA5A5A5A5, WSTRB 4'b0011 -> args[63:32]=0x0000A5A5, BRESP 00 exactly one cycle after the second handshake.
REQ-035 SHALL cover: read 0x0FC with NUM_ARGS=8 -> RRESP 10, RDATA 0; write 0x002 -> BRESP 10 with no register change.
REQ-036 SHALL cover: write CTRL 0x01, then ap_ready pulse -> ap_start falls next cycle; repeat with auto_restart=1 -> ap_start stays 1 and ap_continue pulses once per ap_done.
REQ-037 SHALL cover: ap_done pulse coincident with a CTRL read -> the read returns bit1 per the pre-pulse value and a second read returns bit1=1.
REQ-038 SHALL cover: GIE=1, IER=01, ap_done pulse -> interrupt rises within 2 cycles; write ISR 0x1 -> interrupt falls; same with IER=00 -> no interrupt.
REQ-039 SHALL cover: ARESETn low while BVALID=1 -> BVALID drops immediately, args read 0 after release.

Source files
------------

// File: rtl/krnl_ctrl_pkg.sv
// Shared register map, CTRL bit positions and AXI response codes for the
// kernel control register file.
package krnl_ctrl_pkg;

   localparam logic [31:0] CTRL_OFF = 32'h000;
   localparam logic [31:0] GIE_OFF  = 32'h004;
   localparam logic [31:0] IER_OFF  = 32'h008;
   localparam logic [31:0] ISR_OFF  = 32'h00C;
   localparam logic [31:0] ARG_BASE = 32'h010;

   localparam int CTRL_START = 0;
   localparam int CTRL_DONE  = 1;
   localparam int CTRL_IDLE  = 2;
   localparam int CTRL_READY = 3;
   localparam int CTRL_CONT  = 4;
   localparam int CTRL_AUTO  = 7;

   localparam int ISR_DONE  = 0;
   localparam int ISR_READY = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_CTRL,
      REG_GIE,
      REG_IER,
      REG_ISR,
      REG_ARG
   } reg_sel_e;

   typedef struct packed {
      reg_sel_e   sel;
      logic [5:0] arg_idx;
   } reg_dec_t;

endpackage

// File: rtl/krnl_axi_ctrl_regfile.sv
// AXI4-Lite slave holding the ap_ctrl_chain control/status, interrupt
// registers and a bank of 32-bit kernel argument registers.
module krnl_axi_ctrl_regfile
   import krnl_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int NUM_ARGS = 8,
   parameter int IRQ_EN   = 1
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [ADDR_W-1:0]      AWADDR,
   input  logic                   AWVALID,
   output logic                   AWREADY,
   input  logic [31:0]            WDATA,
   input  logic [3:0]             WSTRB,
   input  logic                   WVALID,
   output logic                   WREADY,
   output logic [1:0]             BRESP,
   output logic                   BVALID,
   input  logic                   BREADY,
   input  logic [ADDR_W-1:0]      ARADDR,
   input  logic                   ARVALID,
   output logic                   ARREADY,
   output logic [31:0]            RDATA,
   output logic [1:0]             RRESP,
   output logic                   RVALID,
   input  logic                   RREADY,
   output logic                   ap_start,
   output logic                   ap_continue,
   input  logic                   ap_done,
   input  logic                   ap_idle,
   input  logic                   ap_ready,
   output logic                   interrupt,
   output logic [NUM_ARGS*32-1:0] args
);

   localparam logic [31:0] ARG_END = ARG_BASE + 32'(4 * NUM_ARGS);

   function automatic reg_dec_t decode(input logic [ADDR_W-1:0] addr);
      logic [31:0] a;
      reg_dec_t    d;
      a         = 32'(addr);
      d.sel     = REG_NONE;
      d.arg_idx = '0;
      if (a[1:0] == 2'b00) begin
         if (a == CTRL_OFF)      d.sel = REG_CTRL;
         else if (a == GIE_OFF)  d.sel = REG_GIE;
         else if (a == IER_OFF)  d.sel = REG_IER;
         else if (a == ISR_OFF)  d.sel = REG_ISR;
         else if (a >= ARG_BASE && a < ARG_END) begin
            d.sel     = REG_ARG;
            d.arg_idx = 6'((a - ARG_BASE) >> 2);
         end
      end
      return d;
   endfunction

   logic              rdy_en_q;
   logic              aw_held_q, aw_held_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic              w_held_q, w_held_d;
   logic [31:0]       w_data_q, w_data_d;
   logic [3:0]        w_strb_q, w_strb_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              start_q, start_d;
   logic              done_q, done_d;
   logic              idle_q, idle_d;
   logic              ready_q, ready_d;
   logic              cont_q, cont_d;
   logic              auto_q, auto_d;
   logic              gie_q, gie_d;
   logic [1:0]        ier_q, ier_d;
   logic [1:0]        isr_q, isr_d;
   logic              irq_q, irq_d;

   logic              aw_hs, w_hs, ar_hs;
   logic              wr_fire, wr_ok, ctrl_wr, ctrl_rd;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;
   reg_dec_t          wdec, rdec;
   logic [31:0]       rd_val;

   assign AWREADY = rdy_en_q & ~aw_held_q & ~bvalid_q;
   assign WREADY  = rdy_en_q & ~w_held_q & ~bvalid_q;
   assign ARREADY = rdy_en_q & ~rvalid_q;

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;
   assign ar_hs = ARVALID & ARREADY;

   // A half arriving this cycle counts as held, so the response follows the
   // second handshake by exactly one cycle.
   assign wr_addr = aw_held_q ? aw_addr_q : AWADDR;
   assign wr_data = w_held_q ? w_data_q : WDATA;
   assign wr_strb = w_held_q ? w_strb_q : WSTRB;
   assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

   assign wdec    = decode(wr_addr);
   assign rdec    = decode(ARADDR);
   assign wr_ok   = wr_fire && (wdec.sel != REG_NONE);
   assign ctrl_wr = wr_ok && (wdec.sel == REG_CTRL) && wr_strb[0];
   assign ctrl_rd = ar_hs && (rdec.sel == REG_CTRL);

   always_comb begin
      rd_val = '0;
      case (rdec.sel)
         REG_CTRL: begin
            rd_val[CTRL_START] = start_q;
            rd_val[CTRL_DONE]  = done_q;
            rd_val[CTRL_IDLE]  = idle_q;
            rd_val[CTRL_READY] = ready_q;
            rd_val[CTRL_CONT]  = cont_q;
            rd_val[CTRL_AUTO]  = auto_q;
         end
         REG_GIE: rd_val[0]   = gie_q;
         REG_IER: rd_val[1:0] = ier_q;
         REG_ISR: rd_val[1:0] = isr_q;
         REG_ARG: begin
            for (int i = 0; i < NUM_ARGS; i++) begin
               if (rdec.arg_idx == 6'(i)) rd_val = args[32*i +: 32];
            end
         end
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      // NOTE: every next-state value starts as a copy of its register, so no branch can infer a latch.
      aw_held_d = aw_held_q;
      aw_addr_d = aw_addr_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = AWADDR;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = WDATA;
         w_strb_d = WSTRB;
      end
      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && BREADY) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = (rdec.sel != REG_NONE) ? RESP_OKAY : RESP_SLVERR;
         rdata_d  = rd_val;
      end else if (rvalid_q && RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_comb begin
      start_d = start_q;
      if (ap_ready && !auto_q) start_d = 1'b0;
      if (ctrl_wr && wr_data[CTRL_START]) start_d = 1'b1;

      auto_d = ctrl_wr ? wr_data[CTRL_AUTO] : auto_q;

      // Cleared when the CTRL read captures its data; a same-cycle pulse survives.
      done_d = done_q;
      if (ctrl_rd) done_d = 1'b0;
      if (ap_done) done_d = 1'b1;

      cont_d  = (ctrl_wr && wr_data[CTRL_CONT]) || (auto_q && ap_done);
      idle_d  = ap_idle;
      ready_d = ap_ready;

      gie_d = gie_q;
      ier_d = ier_q;
      isr_d = isr_q;
      if (wr_ok && wr_strb[0]) begin
         case (wdec.sel)
            REG_GIE: gie_d = wr_data[0];
            REG_IER: ier_d = wr_data[1:0];
            REG_ISR: isr_d = isr_q & ~wr_data[1:0];
            default: ;
         endcase
      end
      if (ap_done && ier_q[ISR_DONE])   isr_d[ISR_DONE]  = 1'b1;
      if (ap_ready && ier_q[ISR_READY]) isr_d[ISR_READY] = 1'b1;
      irq_d = gie_q & (|isr_q);

      if (IRQ_EN == 0) begin
         gie_d = 1'b0;
         ier_d = '0;
         isr_d = '0;
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rdy_en_q  <= 1'b0;
         aw_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         idle_q    <= 1'b0;
         ready_q   <= 1'b0;
         cont_q    <= 1'b0;
         auto_q    <= 1'b0;
         gie_q     <= 1'b0;
         ier_q     <= '0;
         isr_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         rdy_en_q  <= 1'b1;
         aw_held_q <= aw_held_d;
         aw_addr_q <= aw_addr_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         start_q   <= start_d;
         done_q    <= done_d;
         idle_q    <= idle_d;
         ready_q   <= ready_d;
         cont_q    <= cont_d;
         auto_q    <= auto_d;
         gie_q     <= gie_d;
         ier_q     <= ier_d;
         isr_q     <= isr_d;
         irq_q     <= irq_d;
      end
   end

   for (genvar i = 0; i < NUM_ARGS; i++) begin : g_arg
      logic [31:0] arg_q;
      logic        hit;

      assign hit = wr_ok && (wdec.sel == REG_ARG) && (wdec.arg_idx == 6'(i));

      // NOTE: the argument bank is flop-based and cleared by reset so the kernel never sees stale arguments.
      always_ff @(posedge ACLK or negedge ARESETn) begin
         if (!ARESETn) begin
            arg_q <= '0;
         end else if (hit) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_strb[b]) arg_q[8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end

      assign args[32*i +: 32] = arg_q;
   end

   assign BVALID      = bvalid_q;
   assign BRESP       = bresp_q;
   assign RVALID      = rvalid_q;
   assign RRESP       = rresp_q;
   assign RDATA       = rdata_q;
   assign ap_start    = start_q;
   assign ap_continue = cont_q;
   assign interrupt   = irq_q;

endmodule
